// File: rtl/serial_digit_adder_if.sv
// serial_digit_adder_if
//   Operand/result handshake bundle for serial_digit_adder.
//   master: operand source and result consumer (drives in_valid, a, b, c_in,
//           sub, out_ready; observes in_ready, out_valid, s, c_out, ovf, busy).
//   slave : the adder itself.
interface serial_digit_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf, busy
    );
endinterface

// File: rtl/serial_digit_adder.sv
// serial_digit_adder
//   Multi-cycle adder/subtractor: resolves a WIDTH-bit a +/- b +/- c_in
//   DIGIT bits per clock through a DIGIT-long full-adder chain, holding the
//   inter-digit carry in a register. Takes K = WIDTH/DIGIT RUN cycles.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of serial_digit_adder_if (operand handshake, result
//           handshake, s/c_out/ovf result registers, busy)
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for operands, in_ready=1
// S_RUN  | one digit resolved per cycle, K cycles
// S_DONE | result presented, out_valid=1 until out_ready
module serial_digit_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_digit_adder_if.slave bus
);
    localparam int K     = WIDTH / DIGIT;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_digit_adder: WIDTH must be at least 2");
    end
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_digit_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_next;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   s_q;
    logic               c_out_q;
    logic               ovf_q;
    logic               accept;
    logic               last_digit;
    logic [DIGIT:0]     chain_c;
    logic [DIGIT-1:0]   chain_s;

    assign accept     = (state_q == S_IDLE) && bus.in_valid;
    assign last_digit = (state_q == S_RUN) && (cnt_q == CNT_W'(K - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid)  state_d = S_RUN;
            S_RUN:   if (last_digit)    state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Ripple chain over the low digit; chain_c[DIGIT-1] is the carry into the
    // digit's top bit, which on the last digit is the carry into the MSB.
    always_comb begin
        chain_c    = '0;
        chain_s    = '0;
        chain_c[0] = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            chain_s[i]   = a_q[i] ^ b_q[i] ^ chain_c[i];
            chain_c[i+1] = (a_q[i] & b_q[i]) | (chain_c[i] & (a_q[i] ^ b_q[i]));
        end
    end

    // New digit enters at the top so after K shifts the sum is LSB-aligned.
    assign sum_next = (sum_q >> DIGIT) | (WIDTH'(chain_s) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + 1; borrow-in folds into the inverted carry.
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.c_in ^ bus.sub;
            cnt_q   <= '0;
        end else if (state_q == S_RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            sum_q   <= sum_next;
            carry_q <= chain_c[DIGIT];
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_digit) begin
                s_q     <= sum_next;
                c_out_q <= chain_c[DIGIT];
                ovf_q   <= chain_c[DIGIT-1] ^ chain_c[DIGIT];
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.s         = s_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_digit_adder.sv
// tb_serial_digit_adder
//   Directed bench for serial_digit_adder. Three instances share clk/rst_n:
//   index 0 is WIDTH=8/DIGIT=2 (K=4), index 1 is DIGIT=8 (K=1), index 2 is
//   DIGIT=1 (K=8). Index 0 carries the directed scenarios; 1 and 2 carry
//   the random add/sub sweep against an integer reference.
module tb_serial_digit_adder;
    logic       clk;
    logic       rst_n;
    int         n_pass;
    int         n_total;

    logic [2:0] iv;
    logic [2:0] ordy;
    logic [2:0] cin;
    logic [2:0] subm;
    logic [7:0] av [3];
    logic [7:0] bv [3];
    wire  [2:0] irdy;
    wire  [2:0] ovl;
    wire  [2:0] co;
    wire  [2:0] ov;
    wire  [2:0] bsy;
    wire  [7:0] sv [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DIG = (g == 0) ? 2 : ((g == 1) ? 8 : 1);
        serial_digit_adder_if #(.WIDTH(8)) bus ();
        assign bus.in_valid  = iv[g];
        assign bus.out_ready = ordy[g];
        assign bus.c_in      = cin[g];
        assign bus.sub       = subm[g];
        assign bus.a         = av[g];
        assign bus.b         = bv[g];
        assign irdy[g]       = bus.in_ready;
        assign ovl[g]        = bus.out_valid;
        assign co[g]         = bus.c_out;
        assign ov[g]         = bus.ovf;
        assign bsy[g]        = bus.busy;
        assign sv[g]         = bus.s;
        serial_digit_adder #(.WIDTH(8), .DIGIT(DIG)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one operation to instance w (assumed idle) and waits, bounded,
    // for out_valid. lat counts edges from the accept edge to out_valid.
    task automatic do_op(input int w, input logic [7:0] a_i, input logic [7:0] b_i,
                         input logic ci, input logic sb, output int lat, output logic ok);
        av[w]   = a_i;
        bv[w]   = b_i;
        cin[w]  = ci;
        subm[w] = sb;
        ordy[w] = 1'b0;
        iv[w]   = 1'b1;
        step();
        iv[w] = 1'b0;
        lat   = 0;
        while (ovl[w] !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        ok = (ovl[w] === 1'b1);
    endtask

    task automatic release_op(input int w);
        ordy[w] = 1'b1;
        step();
        ordy[w] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_total++; if (irdy[0] !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", irdy[0]); else n_pass++;
        n_total++; if (ovl[0] !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ovl[0]); else n_pass++;
        n_total++; if (bsy[0] !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bsy[0]); else n_pass++;
        n_total++; if (sv[0] !== 8'h00) $display("FAIL reset_s: got %h expected 00", sv[0]); else n_pass++;
        n_total++; if (co[0] !== 1'b0) $display("FAIL reset_c_out: got %b expected 0", co[0]); else n_pass++;
        n_total++; if (ov[0] !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ov[0]); else n_pass++;
    endtask

    task automatic test_add();
        int   lat;
        logic ok;
        do_op(0, 8'h3C, 8'h42, 1'b0, 1'b0, lat, ok);
        n_total++; if (!ok || lat != 4) $display("FAIL add_latency: got %0d (valid=%b) expected 4", lat, ok); else n_pass++;
        n_total++; if (sv[0] !== 8'h7E) $display("FAIL add_s: got %h expected 7e", sv[0]); else n_pass++;
        n_total++; if (co[0] !== 1'b0) $display("FAIL add_c_out: got %b expected 0", co[0]); else n_pass++;
        n_total++; if (ov[0] !== 1'b0) $display("FAIL add_ovf: got %b expected 0", ov[0]); else n_pass++;
        release_op(0);
        n_total++; if (irdy[0] !== 1'b1 || ovl[0] !== 1'b0) $display("FAIL add_return_idle: got in_ready=%b out_valid=%b expected 1/0", irdy[0], ovl[0]); else n_pass++;
        n_total++; if (sv[0] !== 8'h7E) $display("FAIL add_s_held_idle: got %h expected 7e", sv[0]); else n_pass++;
    endtask

    task automatic test_add_carry();
        int   lat;
        logic ok;
        do_op(0, 8'hFF, 8'h01, 1'b1, 1'b0, lat, ok);
        n_total++; if (!ok || sv[0] !== 8'h01) $display("FAIL carry_s: got %h expected 01", sv[0]); else n_pass++;
        n_total++; if (co[0] !== 1'b1) $display("FAIL carry_c_out: got %b expected 1", co[0]); else n_pass++;
        n_total++; if (ov[0] !== 1'b0) $display("FAIL carry_ovf: got %b expected 0", ov[0]); else n_pass++;
        release_op(0);
        do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, lat, ok);
        n_total++; if (!ok || sv[0] !== 8'h80) $display("FAIL ovf_add_s: got %h expected 80", sv[0]); else n_pass++;
        n_total++; if (co[0] !== 1'b0) $display("FAIL ovf_add_c_out: got %b expected 0", co[0]); else n_pass++;
        n_total++; if (ov[0] !== 1'b1) $display("FAIL ovf_add_ovf: got %b expected 1", ov[0]); else n_pass++;
        release_op(0);
    endtask

    task automatic test_sub();
        int   lat;
        logic ok;
        do_op(0, 8'h05, 8'h07, 1'b0, 1'b1, lat, ok);
        n_total++; if (!ok || sv[0] !== 8'hFE) $display("FAIL sub_neg_s: got %h expected fe", sv[0]); else n_pass++;
        n_total++; if (co[0] !== 1'b0) $display("FAIL sub_neg_c_out: got %b expected 0", co[0]); else n_pass++;
        n_total++; if (ov[0] !== 1'b0) $display("FAIL sub_neg_ovf: got %b expected 0", ov[0]); else n_pass++;
        release_op(0);
        do_op(0, 8'h80, 8'h01, 1'b0, 1'b1, lat, ok);
        n_total++; if (!ok || sv[0] !== 8'h7F) $display("FAIL sub_ovf_s: got %h expected 7f", sv[0]); else n_pass++;
        n_total++; if (co[0] !== 1'b1) $display("FAIL sub_ovf_c_out: got %b expected 1", co[0]); else n_pass++;
        n_total++; if (ov[0] !== 1'b1) $display("FAIL sub_ovf_ovf: got %b expected 1", ov[0]); else n_pass++;
        release_op(0);
        do_op(0, 8'h10, 8'h0F, 1'b1, 1'b1, lat, ok);
        n_total++; if (!ok || sv[0] !== 8'h00) $display("FAIL sub_borrow_s: got %h expected 00", sv[0]); else n_pass++;
        n_total++; if (co[0] !== 1'b1) $display("FAIL sub_borrow_c_out: got %b expected 1", co[0]); else n_pass++;
        release_op(0);
    endtask

    task automatic test_backpressure();
        int   lat;
        logic ok;
        do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, lat, ok);
        n_total++; if (!ok || sv[0] !== 8'h46) $display("FAIL bp_s: got %h expected 46", sv[0]); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            iv[0]   = ~iv[0];
            av[0]   = 8'(i * 17);
            bv[0]   = 8'(255 - i);
            subm[0] = ~subm[0];
            step();
            n_total++;
            if (ovl[0] !== 1'b1 || irdy[0] !== 1'b0 || bsy[0] !== 1'b1 || sv[0] !== 8'h46 || co[0] !== 1'b0 || ov[0] !== 1'b0)
                $display("FAIL bp_hold_%0d: got valid=%b ready=%b busy=%b s=%h c=%b v=%b expected 1/0/1/46/0/0",
                         i, ovl[0], irdy[0], bsy[0], sv[0], co[0], ov[0]);
            else
                n_pass++;
        end
        iv[0] = 1'b0;
        release_op(0);
        n_total++; if (irdy[0] !== 1'b1 || ovl[0] !== 1'b0) $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", irdy[0], ovl[0]); else n_pass++;
        step();
        n_total++; if (irdy[0] !== 1'b1 || sv[0] !== 8'h46) $display("FAIL bp_no_accept: got in_ready=%b s=%h expected 1/46", irdy[0], sv[0]); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int   lat;
        logic ok;
        av[0]   = 8'h55;
        bv[0]   = 8'h11;
        cin[0]  = 1'b0;
        subm[0] = 1'b0;
        iv[0]   = 1'b1;
        step();
        iv[0] = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_total++; if (irdy[0] !== 1'b1) $display("FAIL rst_run_in_ready: got %b expected 1", irdy[0]); else n_pass++;
        n_total++; if (ovl[0] !== 1'b0) $display("FAIL rst_run_out_valid: got %b expected 0", ovl[0]); else n_pass++;
        n_total++; if (bsy[0] !== 1'b0) $display("FAIL rst_run_busy: got %b expected 0", bsy[0]); else n_pass++;
        n_total++; if (sv[0] !== 8'h00) $display("FAIL rst_run_s: got %h expected 00", sv[0]); else n_pass++;
        do_op(0, 8'h01, 8'h01, 1'b0, 1'b0, lat, ok);
        n_total++; if (!ok || lat != 4) $display("FAIL rst_fresh_latency: got %0d (valid=%b) expected 4", lat, ok); else n_pass++;
        n_total++; if (sv[0] !== 8'h02) $display("FAIL rst_fresh_s: got %h expected 02", sv[0]); else n_pass++;
        release_op(0);
    endtask

    task automatic test_sweep(input int w, input int exp_lat);
        int         lat;
        logic       ok;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] bb;
        logic       rc;
        logic       rs;
        logic [8:0] full;
        logic       exp_ovf;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(255, 0));
            rb = 8'($urandom_range(255, 0));
            rc = 1'($urandom_range(1, 0));
            rs = 1'($urandom_range(1, 0));
            bb      = rs ? ~rb : rb;
            full    = {1'b0, ra} + {1'b0, bb} + {8'h00, rc ^ rs};
            exp_ovf = (ra[7] == bb[7]) && (full[7] != ra[7]);
            do_op(w, ra, rb, rc, rs, lat, ok);
            n_total++; if (!ok || lat != exp_lat) $display("FAIL sweep%0d_latency: got %0d (valid=%b) expected %0d", w, lat, ok, exp_lat); else n_pass++;
            n_total++; if (sv[w] !== full[7:0]) $display("FAIL sweep%0d_s: a=%h b=%h cin=%b sub=%b got %h expected %h", w, ra, rb, rc, rs, sv[w], full[7:0]); else n_pass++;
            n_total++; if (co[w] !== full[8]) $display("FAIL sweep%0d_c_out: a=%h b=%h cin=%b sub=%b got %b expected %b", w, ra, rb, rc, rs, co[w], full[8]); else n_pass++;
            n_total++; if (ov[w] !== exp_ovf) $display("FAIL sweep%0d_ovf: a=%h b=%h cin=%b sub=%b got %b expected %b", w, ra, rb, rc, rs, ov[w], exp_ovf); else n_pass++;
            release_op(w);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        iv      = '0;
        ordy    = '0;
        cin     = '0;
        subm    = '0;
        for (int i = 0; i < 3; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        test_reset();
        test_add();
        test_add_carry();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_sweep(1, 1);
        test_sweep(2, 8);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
